// File: rtl/mult_share_arbiter.sv
`timescale 1ns/1ps
// mult_share_arbiter
// Round-robin scheduler that time-shares one approximate multiplier among
// N_REQ requesters. One operation at a time: grant, start the multiplier,
// wait for Done (or a watchdog abort), return the product to the winner.
//
// Ports:
//   clk, rst        single rising-edge clock, async active-high reset
//   req             per-requester request level
//   a_in, b_in      packed operands, requester i uses [i*N_INPUT +: N_INPUT]
//   ack             one-hot 1-cycle pulse, operands of that requester latched
//   res_valid       one-hot 1-cycle pulse, result belongs to that requester
//   result          last captured product (0 after a watchdog abort)
//   timeout_err     1-cycle pulse alongside res_valid when the watchdog fired
//   busy            high whenever the FSM is not idle
//   mul_start, mul_a, mul_b   drive multiplier Start/pin1/pin2
//   mul_done, mul_p           multiplier Done/pout
//   dbg_state       current FSM state (IDLE=0, START=1, WAIT=2, RESP=3)
//
// Handshake: a requester raises req[i] with stable operands and holds both
// until it sees ack[i]; ack[i] means the operands were taken and req[i] must
// then drop. A req[i] still high on the next IDLE cycle is a new request.
// The product is delivered later with a res_valid[i] pulse; there is no
// back-pressure on the result side.
module mult_share_arbiter #(
  parameter int N_REQ          = 4,
  parameter int N_INPUT        = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*N_INPUT-1:0]   a_in,
  input  logic [N_REQ*N_INPUT-1:0]   b_in,
  output logic [N_REQ-1:0]           ack,
  output logic [N_REQ-1:0]           res_valid,
  output logic [N_INPUT-1:0]         result,
  output logic                       timeout_err,
  output logic                       busy,
  output logic                       mul_start,
  output logic [N_INPUT-1:0]         mul_a,
  output logic [N_INPUT-1:0]         mul_b,
  input  logic                       mul_done,
  input  logic [N_INPUT-1:0]         mul_p,
  output logic [1:0]                 dbg_state
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0]    G_LAST   = GW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        rr_q, rr_d;
  logic [GW-1:0]        g_q, g_d;
  logic [N_INPUT-1:0]   a_q, a_d;
  logic [N_INPUT-1:0]   b_q, b_d;
  logic [N_INPUT-1:0]   result_q, result_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 to_q, to_d;

  // Circular priority search starting at rr_q.
  logic                 win_found;
  logic [GW-1:0]        win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int cand;
      cand = int'(rr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      g_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      g_q      <= g_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    g_d      = g_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          g_d     = win_idx;
          a_d     = a_in[int'(win_idx)*N_INPUT +: N_INPUT];
          b_d     = b_in[int'(win_idx)*N_INPUT +: N_INPUT];
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done takes priority if it lands on the last watchdog cycle.
        if (mul_done) begin
          result_d = mul_p;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          to_d     = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        rr_d    = (g_q == G_LAST) ? '0 : g_q + 1'b1;
        to_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is a register or a decode of state, never a path from inputs.
  assign ack         = (state_q == S_START) ? (ONE_HOT0 << g_q) : '0;
  assign res_valid   = (state_q == S_RESP)  ? (ONE_HOT0 << g_q) : '0;
  assign timeout_err = (state_q == S_RESP) && to_q;
  assign mul_start   = (state_q == S_START);
  assign busy        = (state_q != S_IDLE);
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign result      = result_q;
  assign dbg_state   = state_q;

endmodule
